// File: rtl/mmio_intc_timer.sv
// Memory-mapped down-counting timer plus edge-latching interrupt controller.
// Six-word register window; drives a single level interrupt to the core.
module mmio_intc_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
    parameter int          NUM_IRQ   = 4
) (
    input  logic               Clk,
    input  logic               Clrn,
    input  logic [31:0]        Daddr,
    input  logic [31:0]        Dwrite,
    input  logic               Wmem,
    input  logic [NUM_IRQ-1:0] Irq,
    output logic [31:0]        Dread,
    output logic               Hit,
    output logic               Intr
);

    localparam int PW = NUM_IRQ + 1;

    logic [1:0]         ctrl_q, ctrl_d;
    logic [31:0]        load_q, load_d;
    logic [31:0]        count_q, count_d;
    logic [PW-1:0]      pend_q, pend_d;
    logic [PW-1:0]      mask_q, mask_d;
    logic [NUM_IRQ-1:0] prev_q, prev_d;

    logic [29:0]   off_w;
    logic          sel_ctrl, sel_load, sel_count;
    logic          sel_pend, sel_mask, sel_cause;
    logic          we;
    logic          tmr_evt;
    logic [PW-1:0] pm;
    logic [PW-1:0] w1c;
    logic [4:0]    cause_idx;
    logic [31:0]   pend_rd, mask_rd;
    logic          unused_addr_lsb;

    assign unused_addr_lsb = ^Daddr[1:0];

    assign off_w     = Daddr[31:2] - BASE_ADDR[31:2];
    assign Hit       = off_w < 30'd6;
    assign sel_ctrl  = Hit && off_w[2:0] == 3'd0;
    assign sel_load  = Hit && off_w[2:0] == 3'd1;
    assign sel_count = Hit && off_w[2:0] == 3'd2;
    assign sel_pend  = Hit && off_w[2:0] == 3'd3;
    assign sel_mask  = Hit && off_w[2:0] == 3'd4;
    assign sel_cause = Hit && off_w[2:0] == 3'd5;
    assign we        = Wmem && Hit;

    assign pm   = pend_q & mask_q;
    assign Intr = |pm;

    always_comb begin
        cause_idx = '0;
        for (int i = PW - 1; i >= 0; i--) begin
            if (pm[i]) cause_idx = 5'(i);
        end
    end

    always_comb begin
        pend_rd = '0;
        mask_rd = '0;
        pend_rd[PW-1:0] = pend_q;
        mask_rd[PW-1:0] = mask_q;
    end

    always_comb begin
        Dread = '0;
        unique case (1'b1)
            sel_ctrl:  Dread = {30'd0, ctrl_q};
            sel_load:  Dread = load_q;
            sel_count: Dread = count_q;
            sel_pend:  Dread = pend_rd;
            sel_mask:  Dread = mask_rd;
            sel_cause: Dread = {Intr, 26'd0, cause_idx};
            default:   Dread = '0;
        endcase
    end

    // A CPU write to COUNT overrides the count step and suppresses expiry.
    always_comb begin
        count_d = count_q;
        tmr_evt = 1'b0;
        if (we && sel_count) begin
            count_d = Dwrite;
        end else if (ctrl_q[0]) begin
            if (count_q > 32'd1) begin
                count_d = count_q - 32'd1;
            end else if (count_q == 32'd1) begin
                tmr_evt = 1'b1;
                count_d = ctrl_q[1] ? load_q : 32'd0;
            end
        end
    end

    // New events take priority over a same-cycle W1C of the same bit.
    always_comb begin
        w1c    = (we && sel_pend) ? Dwrite[PW-1:0] : '0;
        prev_d = Irq;
        pend_d = (pend_q & ~w1c) | {Irq & ~prev_q, tmr_evt};
        ctrl_d = (we && sel_ctrl) ? Dwrite[1:0] : ctrl_q;
        load_d = (we && sel_load) ? Dwrite : load_q;
        mask_d = (we && sel_mask) ? Dwrite[PW-1:0] : mask_q;
    end

    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            ctrl_q  <= '0;
            load_q  <= '0;
            count_q <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            prev_q  <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            load_q  <= load_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            prev_q  <= prev_d;
        end
    end

endmodule

// File: tb/tb_mmio_intc_timer.sv
// Directed and randomized bus traffic against a behavioural model
// of the timer / interrupt controller register window.
module tb_mmio_intc_timer;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int          NI   = 4;
    localparam bit   [31:0] PMSK = (32'd1 << (NI + 1)) - 32'd1;

    localparam int R_CTRL  = 0;
    localparam int R_LOAD  = 1;
    localparam int R_COUNT = 2;
    localparam int R_PEND  = 3;
    localparam int R_MASK  = 4;
    localparam int R_CAUSE = 5;

    logic          Clk;
    logic          Clrn;
    logic [31:0]   Daddr;
    logic [31:0]   Dwrite;
    logic          Wmem;
    logic [NI-1:0] Irq;
    logic [31:0]   Dread;
    logic          Hit;
    logic          Intr;

    mmio_intc_timer #(
        .BASE_ADDR (BASE),
        .NUM_IRQ   (NI)
    ) dut (
        .Clk    (Clk),
        .Clrn   (Clrn),
        .Daddr  (Daddr),
        .Dwrite (Dwrite),
        .Wmem   (Wmem),
        .Irq    (Irq),
        .Dread  (Dread),
        .Hit    (Hit),
        .Intr   (Intr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int vectors;
    int miscompares;

    bit          m_en, m_ar;
    bit [31:0]   m_load, m_count, m_pend, m_mask;
    bit [NI-1:0] m_prev;
    logic [NI-1:0] irq_v;
    logic [31:0] last_rd;

    function automatic void m_reset();
        m_en = 0; m_ar = 0;
        m_load = 0; m_count = 0;
        m_pend = 0; m_mask = 0;
        m_prev = '0;
    endfunction

    function automatic void m_read(input bit [31:0] a,
                                   output bit h,
                                   output bit [31:0] v);
        bit [31:0] pm;
        int        r;
        h = (a >= BASE) && (a <= BASE + 32'h17);
        v = 0;
        if (h) begin
            r = int'((a - BASE) / 4);
            pm = m_pend & m_mask;
            case (r)
                0: v = {30'd0, m_ar, m_en};
                1: v = m_load;
                2: v = m_count;
                3: v = m_pend;
                4: v = m_mask;
                default: begin
                    if (pm != 0) begin
                        for (int i = 0; i < 32; i++) begin
                            if (pm[i]) begin
                                v = 32'h8000_0000 + i;
                                break;
                            end
                        end
                    end
                end
            endcase
        end
    endfunction

    function automatic void m_update(input bit [31:0] a, input bit [31:0] d,
                                     input bit w, input bit [NI-1:0] irq);
        bit        h, we;
        bit [31:0] dummy, nc, ev, clr;
        int        r;
        m_read(a, h, dummy);
        we = w && h;
        r  = h ? int'((a - BASE) / 4) : -1;
        nc = m_count;
        ev = 0;
        if (we && r == R_COUNT) nc = d;
        else if (m_en) begin
            if (m_count > 1) nc = m_count - 1;
            else if (m_count == 1) begin
                ev = 1;
                nc = m_ar ? m_load : 0;
            end
        end
        ev  = ev | ({28'd0, irq & ~m_prev} << 1);
        clr = (we && r == R_PEND) ? (d & PMSK) : 0;
        m_pend = (m_pend & ~clr) | ev;
        if (we && r == R_CTRL) begin
            m_en = d[0];
            m_ar = d[1];
        end
        if (we && r == R_LOAD) m_load = d;
        if (we && r == R_MASK) m_mask = d & PMSK;
        m_prev  = irq;
        m_count = nc;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [31:0] a, input logic [31:0] d,
                        input logic w);
        bit        eh;
        bit [31:0] ed;
        Daddr  = a;
        Dwrite = d;
        Wmem   = w;
        Irq    = irq_v;
        #1;
        m_read(a, eh, ed);
        chk("hit", {31'd0, Hit}, {31'd0, eh});
        chk("dread", Dread, ed);
        chk("intr", {31'd0, Intr}, {31'd0, |(m_pend & m_mask)});
        last_rd = Dread;
        @(posedge Clk);
        if (!Clrn) m_reset();
        else m_update(a, d, w, irq_v);
        #1;
    endtask

    task automatic wr(input int r, input logic [31:0] v);
        step(BASE + 32'(r * 4), v, 1'b1);
    endtask

    task automatic rd(input int r);
        step(BASE + 32'(r * 4) + 32'($urandom_range(0, 3)), $urandom, 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        irq_v       = '0;
        Clrn        = 1'b0;
        Daddr       = '0;
        Dwrite      = '0;
        Wmem        = 1'b0;
        Irq         = '0;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        m_reset();
        Clrn = 1'b1;

        // one-shot
        wr(R_COUNT, 3);
        wr(R_MASK, 1);
        wr(R_CTRL, 1);
        rd(R_COUNT);
        rd(R_COUNT);
        rd(R_COUNT);
        rd(R_PEND);
        chk("oneshot_pend", last_rd, 32'h1);
        chk("oneshot_intr", {31'd0, Intr}, 32'h1);
        rd(R_COUNT);
        rd(R_COUNT);
        chk("oneshot_hold", last_rd, 32'h0);

        // auto-reload
        wr(R_PEND, 1);
        wr(R_LOAD, 4);
        wr(R_COUNT, 4);
        wr(R_CTRL, 3);
        for (int i = 0; i < 14; i++) rd(i % 6);
        wr(R_PEND, 1);
        for (int i = 0; i < 6; i++) rd(R_COUNT);

        // W1C collides with expiry
        wr(R_COUNT, 1);
        wr(R_PEND, 1);
        rd(R_PEND);
        chk("w1c_vs_evt", last_rd & 32'h1, 32'h1);

        // COUNT write collides with expiry
        wr(R_CTRL, 0);
        wr(R_PEND, PMSK);
        wr(R_COUNT, 1);
        wr(R_CTRL, 1);
        wr(R_COUNT, 7);
        rd(R_COUNT);
        chk("cntwr_val", last_rd, 32'd7);
        rd(R_PEND);
        chk("cntwr_noevt", last_rd, 32'h0);
        wr(R_CTRL, 0);

        // edge IRQ
        wr(R_MASK, 8);
        irq_v = 4'b0100;
        rd(R_PEND);
        rd(R_PEND);
        chk("edge_pend", last_rd, 32'h8);
        rd(R_CAUSE);
        chk("edge_cause", last_rd, 32'h8000_0003);
        wr(R_PEND, 8);
        for (int i = 0; i < 5; i++) rd(R_PEND);
        chk("edge_rearm", last_rd, 32'h0);
        irq_v = '0;
        rd(R_PEND);

        // priority and masking
        irq_v = 4'b0011;
        rd(R_PEND);
        irq_v = '0;
        rd(R_PEND);
        chk("prio_pend", last_rd, 32'h6);
        wr(R_MASK, 4);
        rd(R_CAUSE);
        chk("prio_cause", last_rd, 32'h8000_0002);
        wr(R_MASK, 0);
        rd(R_CAUSE);
        chk("mask_cause", last_rd, 32'h0);
        chk("mask_intr", {31'd0, Intr}, 32'h0);
        rd(R_PEND);
        chk("mask_keep", last_rd, 32'h6);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, d;
            int          r;
            r = $urandom_range(0, 9);
            if (r == 8) a = 32'h40;
            else if (r == 9) a = BASE - 32'd4;
            else a = BASE + 32'(r * 4) + 32'($urandom_range(0, 3));
            d = $urandom_range(0, 1) ? 32'($urandom_range(0, 8)) : $urandom;
            if ($urandom_range(0, 3) == 0) irq_v = 4'($urandom_range(0, 15));
            step(a, d, $urandom_range(0, 2) == 0);
        end

        // reset after random writes
        irq_v = '0;
        wr(R_LOAD, $urandom);
        wr(R_MASK, PMSK);
        Clrn = 1'b0;
        wr(R_COUNT, 32'd9);
        Clrn = 1'b1;
        for (int r = 0; r < 6; r++) begin
            rd(r);
            chk("rst_reg", last_rd, 32'h0);
        end
        step(32'h40, 32'h0, 1'b0);
        chk("rst_nohit", {31'd0, Hit}, 32'h0);
        chk("rst_intr", {31'd0, Intr}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
